sensor_period_capture: RTL and testbench

- Upstream front end of the theremin sensor filter chain.
- Synchronises the raw oscillator square wave and measures the total number of CLK cycles spanned by 2^AVG_SHIFT consecutive input periods.
- Publishes each result as a DATA_BITS value, together with the free-running PHASE strobe that the downstream 2-phase filter stages consume.
- Detects a stalled oscillator and reports a saturated value.

---
 rtl/sensor_period_capture.sv | 182 ++++++++++++++++++
 tb/tb_sensor_period_capture.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_period_capture.sv
`default_nettype none
// ============================================================================
// Module   : sensor_period_capture
// Purpose  : Front end of the theremin sensor filter chain. Synchronises the
//            raw oscillator square wave and counts the CLK cycles spanned by
//            2^AVG_SHIFT consecutive input periods. Each result is handed to
//            the downstream 2-phase filter only on its sampling phase
//            (PHASE==0). A stalled oscillator is reported as an all-ones
//            value together with the TIMEOUT flag.
// Revision : 1.0 - initial release
// ============================================================================
module sensor_period_capture #(
  parameter int DATA_BITS  = 32,  // width of OUT_VALUE, >= COUNT_BITS+1
  parameter int COUNT_BITS = 24,  // width of the window cycle counter
  parameter int AVG_SHIFT  = 4    // window length is 2^AVG_SHIFT periods (0..8)
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 FREQ_IN,
  output logic                 PHASE,
  output logic [DATA_BITS-1:0] OUT_VALUE,
  output logic                 OUT_VALID,
  output logic                 TIMEOUT
);

  // Edge counter needs at least one bit, even when a window is one period.
  localparam int EDGE_W = (AVG_SHIFT > 0) ? AVG_SHIFT : 1;

  // Index of the rising edge that closes a window (N-1).
  localparam logic [EDGE_W-1:0] c_last_edge = EDGE_W'((1 << AVG_SHIFT) - 1);

  // Counter value at which the oscillator is declared stalled.
  localparam logic [COUNT_BITS-1:0] c_cnt_max = '1;

  typedef enum logic [1:0] {
    ST_WAIT_FIRST = 2'd0,
    ST_MEASURE    = 2'd1,
    ST_TIMEOUT    = 2'd2
  } state_t;

  // Input synchroniser
  logic r_s1;
  logic r_s2;
  logic r_s3;
  logic w_rise;

  // Measurement state
  state_t              r_state;
  logic [COUNT_BITS-1:0] r_cnt;
  logic [EDGE_W-1:0]     r_edge_cnt;
  logic                  r_timeout;

  // Result handoff
  logic                 r_phase;
  logic                 r_pend_valid;
  logic [DATA_BITS-1:0] r_pend_value;
  logic [DATA_BITS-1:0] r_out_value;
  logic                 r_out_valid;

  // Combinational event decode
  logic                  w_close;
  logic                  w_stall;
  logic [COUNT_BITS:0]   w_result;
  logic                  w_new_valid;
  logic [DATA_BITS-1:0]  w_new_value;
  logic                  w_pend_valid_nxt;
  logic [DATA_BITS-1:0]  w_pend_value_nxt;

  // Three-flop synchroniser for the asynchronous oscillator input.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= FREQ_IN;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // Only rising edges of the oscillator are measured.
  assign w_rise = r_s2 & ~r_s3;

  // Decode window close / stall events and the resulting pending value.
  always_comb begin
    w_close  = (r_state == ST_MEASURE) && w_rise && (r_edge_cnt == c_last_edge);
    // A closing edge wins over the stall check, so cnt==max on a closing
    // edge still yields the legal maximum 2^COUNT_BITS.
    w_stall  = (r_state == ST_MEASURE) && !w_close && (r_cnt == c_cnt_max);
    w_result = {1'b0, r_cnt} + (COUNT_BITS + 1)'(1);

    w_new_valid = w_close | w_stall;
    w_new_value = w_stall ? {DATA_BITS{1'b1}} : DATA_BITS'(w_result);

    // Newer result always overwrites an unpublished one.
    w_pend_valid_nxt = w_new_valid | r_pend_valid;
    w_pend_value_nxt = w_new_valid ? w_new_value : r_pend_value;
  end

  // Measurement FSM: window counters and the registered TIMEOUT flag.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state    <= ST_WAIT_FIRST;
      r_cnt      <= '0;
      r_edge_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      case (r_state)
        ST_WAIT_FIRST: begin
          // First edge only arms; the partial period before it is unknown.
          if (w_rise) begin
            r_state    <= ST_MEASURE;
            r_cnt      <= '0;
            r_edge_cnt <= '0;
          end
        end

        ST_MEASURE: begin
          if (w_close) begin
            // Next window starts at this edge, keeping periods contiguous.
            r_cnt      <= '0;
            r_edge_cnt <= '0;
          end else if (w_stall) begin
            r_state   <= ST_TIMEOUT;
            r_timeout <= 1'b1;
          end else if (w_rise) begin
            r_edge_cnt <= r_edge_cnt + EDGE_W'(1);
            r_cnt      <= r_cnt + COUNT_BITS'(1);
          end else begin
            r_cnt <= r_cnt + COUNT_BITS'(1);
          end
        end

        ST_TIMEOUT: begin
          // Any edge proves the oscillator is alive again; re-arm.
          if (w_rise) begin
            r_state    <= ST_MEASURE;
            r_cnt      <= '0;
            r_edge_cnt <= '0;
            r_timeout  <= 1'b0;
          end
        end

        default: begin
          r_state   <= ST_WAIT_FIRST;
          r_timeout <= 1'b0;
        end
      endcase
    end
  end

  // Free-running phase strobe and publish of pending results on PHASE==1
  // edges, so outputs only change in the filter's sampling phase.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_phase      <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_value <= '0;
      r_out_value  <= '0;
      r_out_valid  <= 1'b0;
    end else begin
      r_phase <= ~r_phase;
      if (r_phase && w_pend_valid_nxt) begin
        r_out_value  <= w_pend_value_nxt;
        r_out_valid  <= 1'b1;
        r_pend_valid <= 1'b0;
      end else begin
        r_out_valid  <= 1'b0;
        r_pend_valid <= w_pend_valid_nxt;
        r_pend_value <= w_pend_value_nxt;
      end
    end
  end

  assign PHASE     = r_phase;
  assign OUT_VALUE = r_out_value;
  assign OUT_VALID = r_out_valid;
  assign TIMEOUT   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_sensor_period_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_sensor_period_capture
// Purpose  : Self-checking bench for sensor_period_capture (N=4, 8-bit
//            counter). An event-time model predicts outputs every cycle;
//            directed scenarios pin the model with literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sensor_period_capture;

  localparam int DB    = 32;
  localparam int CB    = 8;
  localparam int AS    = 2;
  localparam int N     = 4;
  localparam int STALL = 256;   // cycles after window start that mean stalled

  logic          CLK     = 1'b0;
  logic          RESET   = 1'b1;
  logic          FREQ_IN = 1'b0;
  logic          PHASE;
  logic [DB-1:0] OUT_VALUE;
  logic          OUT_VALID;
  logic          TIMEOUT;

  int n_cmp = 0;
  int n_err = 0;

  sensor_period_capture #(
    .DATA_BITS (DB),
    .COUNT_BITS(CB),
    .AVG_SHIFT (AS)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .FREQ_IN  (FREQ_IN),
    .PHASE    (PHASE),
    .OUT_VALUE(OUT_VALUE),
    .OUT_VALID(OUT_VALID),
    .TIMEOUT  (TIMEOUT)
  );

  always #5 CLK = ~CLK;

  // ---------------- oscillator generator ----------------
  int g_per  = 10;   // fixed period when g_mode==0
  int g_mode = 0;    // 1: alternate 9/11 periods
  bit g_run  = 1'b0; // 0: hold FREQ_IN low
  bit g_rand = 1'b0; // random sub-cycle drive offset
  int g_ph   = 0;
  int g_cur  = 10;
  bit g_alt  = 1'b0;

  initial begin
    forever begin
      @(posedge CLK);
      if (g_rand) #($urandom_range(1, 9));
      else #2;
      if (!g_run) begin
        FREQ_IN = 1'b0;
        g_ph    = 0;
      end else begin
        if (g_ph == 0) begin
          if (g_mode == 1) begin
            g_cur = g_alt ? 11 : 9;
            g_alt = !g_alt;
          end else begin
            g_cur = g_per;
          end
        end
        FREQ_IN = (g_ph < (g_cur + 1) / 2) ? 1'b1 : 1'b0;
        g_ph    = (g_ph + 1 >= g_cur) ? 0 : g_ph + 1;
      end
    end
  end

  // ---------------- behavioural model ----------------
  // Time is counted in clock edges since reset. A rise is seen at edge e
  // when FREQ_IN was sampled 1 at edge e-2 and 0 at edge e-3. A window's
  // result is simply the edge distance between its start and closing rise.
  bit          m_ok = 1'b0;
  int          m_e;
  bit          h1, h2, h3;
  bit          m_armed, m_stalled;
  int          m_start, m_rises;
  bit          m_pend;
  logic [31:0] m_pval, m_val;
  bit          m_valid, m_timeout, m_phase;

  always @(posedge CLK) begin
    bit          rise;
    bit          have;
    logic [31:0] res;
    if (RESET) begin
      m_ok = 1'b1; m_e = 0; h1 = 0; h2 = 0; h3 = 0;
      m_armed = 0; m_stalled = 0; m_start = 0; m_rises = 0;
      m_pend = 0; m_pval = '0; m_val = '0; m_valid = 0; m_timeout = 0; m_phase = 0;
    end else begin
      m_e++;
      rise = h2 & ~h3;
      h3 = h2; h2 = h1; h1 = FREQ_IN;
      have = 1'b0;
      res  = '0;
      if (m_stalled) begin
        if (rise) begin m_stalled = 0; m_armed = 1; m_start = m_e; m_rises = 0; end
      end else if (!m_armed) begin
        if (rise) begin m_armed = 1; m_start = m_e; m_rises = 0; end
      end else if (rise && m_rises == N - 1) begin
        have = 1'b1; res = m_e - m_start; m_start = m_e; m_rises = 0;
      end else if (m_e - m_start == STALL) begin
        have = 1'b1; res = '1; m_armed = 0; m_stalled = 1;
      end else if (rise) begin
        m_rises++;
      end
      m_timeout = m_stalled;
      if (have) begin m_pend = 1'b1; m_pval = res; end
      m_valid = 1'b0;
      if (m_phase && m_pend) begin m_val = m_pval; m_valid = 1'b1; m_pend = 1'b0; end
      m_phase = ~m_phase;
    end
  end

  // Compare all outputs against the model every cycle.
  always @(negedge CLK) begin
    if (m_ok) begin
      n_cmp++;
      if (PHASE !== m_phase || OUT_VALUE !== m_val || OUT_VALID !== m_valid || TIMEOUT !== m_timeout) begin
        n_err++;
        $display("FAIL cycle_check t=%0t: got phase=%0b val=%h valid=%0b to=%0b, want phase=%0b val=%h valid=%0b to=%0b",
                 $time, PHASE, OUT_VALUE, OUT_VALID, TIMEOUT, m_phase, m_val, m_valid, m_timeout);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic wait_valid(input int budget, output logic [31:0] v, output int waited);
    bit found;
    found  = 1'b0;
    v      = '0;
    waited = 0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge CLK);
      waited++;
      if (OUT_VALID === 1'b1) begin
        v     = OUT_VALUE;
        found = 1'b1;
      end
    end
    if (!found) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_valid: got no OUT_VALID in %0d cycles, want one", budget);
    end
  endtask

  task automatic skip_results(input int k, input int budget);
    logic [31:0] v;
    int          w;
    for (int i = 0; i < k; i++) wait_valid(budget, v, w);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    logic [31:0] v;
    int          w;
    int          toggles;
    logic        prev;

    RESET = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    @(negedge CLK);
    chk("rst_phase", 32'(PHASE), 32'd0);
    chk("rst_value", OUT_VALUE, 32'd0);
    chk("rst_valid", 32'(OUT_VALID), 32'd0);
    chk("rst_timeout", 32'(TIMEOUT), 32'd0);
    @(posedge CLK);
    #1 RESET = 1'b0;

    // 1: period 10
    g_per = 10; g_mode = 0; g_run = 1'b1;
    wait_valid(200, v, w);
    chk("t1_first", v, 32'd40);
    chk("t1_model", m_val, 32'd40);
    chk("t1_phase", 32'(PHASE), 32'd0);
    chk("t1_timeout", 32'(TIMEOUT), 32'd0);
    chk("t1_latency_ok", 32'(w >= 40 && w <= 46), 32'd1);
    wait_valid(60, v, w);
    chk("t1_second", v, 32'd40);

    // 2: alternating 9/11, then period 7
    g_mode = 1;
    skip_results(2, 60);
    wait_valid(60, v, w);
    chk("t2_alt_a", v, 32'd40);
    wait_valid(60, v, w);
    chk("t2_alt_b", v, 32'd40);
    g_mode = 0; g_per = 7;
    skip_results(2, 60);
    wait_valid(60, v, w);
    chk("t2_p7", v, 32'd28);
    chk("t2_model", m_val, 32'd28);

    // 3: stall, then recovery
    g_run = 1'b0;
    wait_valid(400, v, w);
    chk("t3_stall_val", v, 32'hFFFF_FFFF);
    chk("t3_model", m_val, 32'hFFFF_FFFF);
    chk("t3_timeout", 32'(TIMEOUT), 32'd1);
    repeat (20) @(negedge CLK);
    chk("t3_timeout_held", 32'(TIMEOUT), 32'd1);
    chk("t3_value_held", OUT_VALUE, 32'hFFFF_FFFF);
    g_per = 10; g_run = 1'b1;
    w = 0;
    while (TIMEOUT === 1'b1 && w < 30) begin @(negedge CLK); w++; end
    chk("t3_timeout_clear", 32'(TIMEOUT), 32'd0);
    wait_valid(100, v, w);
    chk("t3_recover", v, 32'd40);

    // 4: period 64, closing edge at the counter limit
    g_per = 64;
    skip_results(2, 600);
    wait_valid(600, v, w);
    chk("t4_max", v, 32'd256);
    chk("t4_model", m_val, 32'd256);
    chk("t4_timeout", 32'(TIMEOUT), 32'd0);

    // 5: reset mid-window
    g_per = 10;
    skip_results(2, 300);
    wait_valid(100, v, w);
    repeat (22) @(posedge CLK);
    #1 RESET = 1'b1;
    @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    chk("t5_phase", 32'(PHASE), 32'd0);
    chk("t5_value", OUT_VALUE, 32'd0);
    chk("t5_valid", 32'(OUT_VALID), 32'd0);
    chk("t5_timeout", 32'(TIMEOUT), 32'd0);
    wait_valid(100, v, w);
    chk("t5_after", v, 32'd40);
    chk("t5_latency_ok", 32'(w >= 40), 32'd1);

    // 6: period 2 with random drive offsets
    g_per = 2; g_rand = 1'b1;
    skip_results(2, 100);
    wait_valid(40, v, w);
    chk("t6_a", v, 32'd8);
    wait_valid(40, v, w);
    chk("t6_b", v, 32'd8);
    toggles = 0;
    prev    = PHASE;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (PHASE !== prev) toggles++;
      prev = PHASE;
    end
    chk("t6_phase_toggle", 32'(toggles), 32'd10);
    g_rand = 1'b0;

    repeat (3) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
